fir_coeff_bank: RTL and testbench

FIR_COEFF_BANK -- requirements
Module: fir_coeff_bank

---
 rtl/fir_coeff_bank.sv | 154 +++++++++++++++
 tb/tb_fir_coeff_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: coefficient store for the FIR filter.
//
// The command decoder loads coefficient words one after another. The next
// free location is always mem[wr_cnt]. A clear command walks through every
// word and writes it to zero, one word per clock. The filter datapath reads
// a tap through a registered port, so read data appears one cycle after the
// address.
//
// Optional build macro: FIR_COEFF_SYMMETRIC_EN
//   Undefined: NTAPS stores are accepted, and rd_addr selects a word directly.
//   Defined:   only NTAPS/2 stores are accepted, and the upper half of the
//              tap range mirrors the lower half (linear-phase filter). The
//              clear sweep still zeroes all NTAPS words.
//
// Parameters: NTAPS (word count, power of two, >= 4), CW (word width),
//             AW (address width, log2(NTAPS))
// Ports:
//   clk       in   clock; every register updates on its rising edge
//   rst       in   asynchronous reset, active high
//   c_sto     in   one-cycle store strobe; coeff_in is sampled in that cycle
//   c_clr     in   one-cycle clear-all strobe
//   coeff_in  in   [CW-1:0] coefficient word to store
//   rd_addr   in   [AW-1:0] tap read address
//   rd_data   out  [CW-1:0] registered coefficient at rd_addr
//   busy      out  high while a clear sweep is in progress
//   full      out  high when every writable location has been loaded
//   err       out  sticky flag; set when a store is dropped
//   wr_cnt    out  [AW:0] number of words loaded since the last clear
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | accepting stores and clear commands
// CLEARING | zeroing mem[sweep_ptr], one word per cycle

module fir_coeff_bank #(
  parameter int NTAPS = 8,
  parameter int CW    = 16,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_sto,
  input  logic          c_clr,
  input  logic [CW-1:0] coeff_in,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  output logic          busy,
  output logic          full,
  output logic          err,
  output logic [AW:0]   wr_cnt
);

  typedef enum logic {IDLE, CLEARING} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NTAPS - 1);
`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam logic [AW:0]   CAP       = (AW+1)'(NTAPS / 2);
  localparam logic [AW-1:0] HALF_ADDR = AW'(NTAPS / 2);
`else
  localparam logic [AW:0]   CAP       = (AW+1)'(NTAPS);
`endif

  state_t        state_q, state_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          err_q, err_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [CW-1:0] mem_wdata;
  logic [AW-1:0] rd_eff;

  logic [CW-1:0] mem [NTAPS];

  // wr_cnt stops at CAP, so full stays up until a clear and the count never wraps.
  assign full   = (wr_cnt_q == CAP);
  assign busy   = (state_q == CLEARING);
  assign err    = err_q;
  assign wr_cnt = wr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      sweep_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      sweep_q  <= sweep_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    sweep_d   = sweep_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = wr_cnt_q[AW-1:0];
    mem_wdata = coeff_in;
    case (state_q)
      IDLE: begin
        // A clear command takes priority, and a store in the same cycle is ignored.
        if (c_clr) begin
          state_d = CLEARING;
          sweep_d = '0;
        end else if (c_sto) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + (AW+1)'(1);
          end
        end
      end
      CLEARING: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        sweep_d   = sweep_q + AW'(1);
        if (c_sto) err_d = 1'b1;
        // The cycle that clears the last word ends the sweep.
        // A store in that same cycle is dropped, and err still ends at 0.
        if (sweep_q == LAST_ADDR) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
          err_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef FIR_COEFF_SYMMETRIC_EN
  // Taps in the upper half read their mirror image in the lower half.
  assign rd_eff = (rd_addr >= HALF_ADDR) ? (LAST_ADDR - rd_addr) : rd_addr;
`else
  assign rd_eff = rd_addr;
`endif

  // The memory write above also takes effect on this edge.
  // A read and a write to the same word in one cycle therefore returns the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_eff];
  end

endmodule

// File: tb/tb_fir_coeff_bank.sv
module tb_fir_coeff_bank;
  localparam int NTAPS = 8;
  localparam int CW    = 16;
  localparam int AW    = 3;
`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam int CAP = NTAPS / 2;
`else
  localparam int CAP = NTAPS;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          c_sto;
  logic          c_clr;
  logic [CW-1:0] coeff_in;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
  logic          busy;
  logic          full;
  logic          err;
  logic [AW:0]   wr_cnt;

  always #5 clk = ~clk;

  fir_coeff_bank #(.NTAPS(NTAPS), .CW(CW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .c_sto(c_sto), .c_clr(c_clr), .coeff_in(coeff_in),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .full(full),
    .err(err), .wr_cnt(wr_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: word contents, a flag per word saying whether its value is known,
  // the load count, the sticky error, and how many sweep cycles remain.
  int mem_m [NTAPS];
  bit val_m [NTAPS];
  int cnt_m;
  int clear_left;
  bit err_m;
  int rd_m;
  bit rd_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int map_addr(input int a);
    if (CAP < NTAPS && a >= NTAPS / 2) return NTAPS - 1 - a;
    return a;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".busy"},   busy,   clear_left > 0);
    chk({tag, ".full"},   full,   cnt_m == CAP);
    chk({tag, ".err"},    err,    err_m);
    chk({tag, ".wr_cnt"}, wr_cnt, cnt_m);
    if (rd_val) chk({tag, ".rd_data"}, rd_data, rd_m);
  endtask

  // Called just after a falling edge. Drives the inputs for one cycle,
  // steps the model on the rising edge, and checks the outputs on the next falling edge.
  task automatic step(input bit sto, input bit clr, input logic [CW-1:0] d,
                      input int a, input string tag);
    int idx;
    c_sto = sto; c_clr = clr; coeff_in = d; rd_addr = AW'(a);
    @(posedge clk);
    rd_val = val_m[map_addr(a)];
    rd_m   = mem_m[map_addr(a)];
    if (clear_left > 0) begin
      idx = NTAPS - clear_left;
      mem_m[idx] = 0;
      val_m[idx] = 1'b1;
      if (sto) err_m = 1'b1;
      clear_left--;
      if (clear_left == 0) begin
        cnt_m = 0;
        err_m = 1'b0;
      end
    end else if (clr) begin
      clear_left = NTAPS;
    end else if (sto) begin
      if (cnt_m == CAP) err_m = 1'b1;
      else begin
        mem_m[cnt_m] = d;
        val_m[cnt_m] = 1'b1;
        cnt_m++;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic model_reset();
    cnt_m = 0; clear_left = 0; err_m = 1'b0; rd_m = 0; rd_val = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".busy"},    busy,    1'b0);
    chk({tag, ".full"},    full,    1'b0);
    chk({tag, ".err"},     err,     1'b0);
    chk({tag, ".wr_cnt"},  wr_cnt,  0);
    chk({tag, ".rd_data"}, rd_data, 0);
  endtask

  initial begin
    int nb;
    for (int i = 0; i < NTAPS; i++) begin
      mem_m[i] = 0;
      val_m[i] = 1'b0;
    end
    model_reset();
    rst = 1'b1; c_sto = 1'b0; c_clr = 1'b0; coeff_in = '0; rd_addr = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Clear, then load 0x0011..0x0088 and read every tap back.
    step(1'b0, 1'b1, 16'h0, 0, "clr0");
    for (int i = 0; i < NTAPS; i++) step(1'b0, 1'b0, 16'h0, i, "sweep0");
    for (int i = 0; i < NTAPS; i++) step(1'b1, 1'b0, 16'(16'h11 * (i + 1)), 0, "load");
    for (int i = 0; i < NTAPS; i++) begin
      step(1'b0, 1'b0, 16'h0, i, "readback");
`ifndef FIR_COEFF_SYMMETRIC_EN
      chk("load_rd", rd_data, 16'(16'h11 * (i + 1)));
`endif
    end
`ifndef FIR_COEFF_SYMMETRIC_EN
    chk("load_full", full, 1'b1);
    chk("load_cnt", wr_cnt, 8);
`endif

    // A store while full is dropped and sets err.
    step(1'b1, 1'b0, 16'hFFFF, 7, "overflow");
    chk("overflow_err", err, 1'b1);
    for (int i = 0; i < NTAPS; i++) step(1'b0, 1'b0, 16'h0, i, "after_ovf");

    // c_clr together with c_stowith store: busy must stay high for exactly NTAPS cycles.
    nb = 0;
    step(1'b1, 1'b1, 16'hABCD, 0, "clr_sto");
    for (int i = 0; i < NTAPS + 4; i++) begin
      if (busy) nb++;
      step(1'b0, 1'b0, 16'h0, i % NTAPS, "clr_sweep");
    end
    chk("sweep_len", nb, NTAPS);
    for (int i = 0; i < NTAPS; i++) begin
      step(1'b0, 1'b0, 16'h0, i, "clr_read");
      chk("clr_rd_zero", rd_data, 0);
    end
    chk("clr_cnt", wr_cnt, 0);
    chk("clr_err", err, 1'b0);

    // A store during the sweep sets err, and the end of the sweep clears it.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(i + 5), 0, "pre_load");
    step(1'b0, 1'b1, 16'h0, 0, "clr2");
    step(1'b0, 1'b0, 16'h0, 0, "sw2_c1");
    step(1'b0, 1'b0, 16'h0, 0, "sw2_c2");
    step(1'b1, 1'b0, 16'h1234, 0, "sw2_sto");
    chk("sweep_sto_err", err, 1'b1);
    for (int i = 0; i < NTAPS; i++) step(1'b0, 1'b0, 16'h0, i, "sw2_rest");
    chk("sweep_end_err", err, 1'b0);

    // A reset in the middle of a sweep stops it at once.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 16'(16'h700 + i), 0, "pre_rst");
    step(1'b0, 1'b1, 16'h0, 0, "clr3");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 0, "sw3");
    rst = 1'b1;
    #1;
    check_reset("mid_sweep_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0, 0, "post_rst");
    chk("post_rst_busy", busy, 1'b0);

    // Randomised traffic.
    step(1'b0, 1'b1, 16'h0, 0, "rclr");
    for (int i = 0; i < 700; i++) begin
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3,
           16'($urandom), int'($urandom_range(0, NTAPS - 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
